// File: rtl/drone_ctrl_top.sv
// Quad-rotor speed controller: registers commands, derives per-motor rpm targets,
// then drives each motor with a saturated proportional correction against its sensor.
module drone_ctrl_top #(
   parameter int HOVER_RPM = 2750,
   parameter int ALT_STEP  = 400,
   parameter int DIR_STEP  = 200,
   parameter int MAX_RPM   = 5500,
   parameter int KP_SHIFT  = 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic signed [2:0]  altcmd,
   input  logic signed [2:0]  dircmd    [1:0],
   input  logic signed [15:0] rpm_sense [3:0],
   output logic signed [15:0] mot_set   [3:0]
);

   localparam int TW = 20;
   localparam logic signed [TW-1:0] HOVER_W = TW'(HOVER_RPM);
   localparam logic signed [TW-1:0] ALT_W   = TW'(ALT_STEP);
   localparam logic signed [TW-1:0] DIR_W   = TW'(DIR_STEP);
   localparam logic signed [TW-1:0] MAX_W   = TW'(MAX_RPM);
   localparam logic signed [17:0]   SAT_HI  = 18'sd32767;
   localparam logic signed [17:0]   SAT_LO  = -18'sd32768;

   logic signed [2:0]    alt_q;
   logic signed [2:0]    dir_q     [1:0];
   logic signed [15:0]   target_q  [3:0];

   logic signed [TW-1:0] base;
   logic signed [TW-1:0] lat_d;
   logic signed [TW-1:0] lon_d;
   logic signed [TW-1:0] tgt_raw   [3:0];
   logic signed [15:0]   tgt_clamp [3:0];
   logic signed [15:0]   sense_c   [3:0];
   logic signed [17:0]   err       [3:0];
   logic signed [17:0]   err_sh    [3:0];
   logic signed [15:0]   mot_next  [3:0];

   function automatic logic signed [15:0] clamp_rpm(input logic signed [TW-1:0] v);
      if (v < 0)
         return '0;
      else if (v > MAX_W)
         return MAX_W[15:0];
      else
         return v[15:0];
   endfunction

   // Motor order is left, right, front, rear; lateral and longitudinal
   // commands push opposite motor pairs apart around the common base.
   always_comb begin
      base       = HOVER_W + TW'(alt_q) * ALT_W;
      lat_d      = TW'(dir_q[0]) * DIR_W;
      lon_d      = TW'(dir_q[1]) * DIR_W;
      tgt_raw[0] = base + lat_d;
      tgt_raw[1] = base - lat_d;
      tgt_raw[2] = base - lon_d;
      tgt_raw[3] = base + lon_d;
      for (int unsigned i = 0; i < 4; i++) begin
         tgt_clamp[i] = clamp_rpm(tgt_raw[i]);
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         sense_c[i] = clamp_rpm(TW'(rpm_sense[i]));
         err[i]     = 18'(target_q[i]) - 18'(sense_c[i]);
         err_sh[i]  = err[i] <<< KP_SHIFT;
         if (err_sh[i] > SAT_HI)
            mot_next[i] = 16'sh7fff;
         else if (err_sh[i] < SAT_LO)
            mot_next[i] = 16'sh8000;
         else
            mot_next[i] = err_sh[i][15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         alt_q    <= '0;
         dir_q[0] <= '0;
         dir_q[1] <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            target_q[i] <= '0;
            mot_set[i]  <= '0;
         end
      end else begin
         alt_q    <= altcmd;
         dir_q[0] <= dircmd[0];
         dir_q[1] <= dircmd[1];
         for (int unsigned i = 0; i < 4; i++) begin
            target_q[i] <= tgt_clamp[i];
            mot_set[i]  <= mot_next[i];
         end
      end
   end

endmodule

// File: tb/tb_drone_ctrl_top.sv
// Bench for drone_ctrl_top: reset behaviour, pipelined open-loop vectors via a
// scoreboard, and closed-loop settling against an integrating plant.
module tb_drone_ctrl_top;

   logic               clk = 1'b0;
   logic               resetn;
   logic signed [2:0]  altcmd;
   logic signed [2:0]  dircmd    [1:0];
   logic signed [15:0] rpm_sense [3:0];
   logic signed [15:0] mot_set   [3:0];

   int errors = 0;
   int checks = 0;
   int plant [4];
   int exp_q [$];

   typedef struct packed {
      int alt, d0, d1;
      int s0, s1, s2, s3;
      int m0, m1, m2, m3;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   drone_ctrl_top #(
      .HOVER_RPM(2750),
      .ALT_STEP (400),
      .DIR_STEP (200),
      .MAX_RPM  (5500),
      .KP_SHIFT (1)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .altcmd   (altcmd),
      .dircmd   (dircmd),
      .rpm_sense(rpm_sense),
      .mot_set  (mot_set)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_near(input string name, input int act, input int exp, input int tol);
      checks++;
      if (act < exp - tol || act > exp + tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   task automatic set_cmd(input int a, input int d0, input int d1);
      altcmd    = 3'(a);
      dircmd[0] = 3'(d0);
      dircmd[1] = 3'(d1);
   endtask

   task automatic check_mot_all(input string name, input int exp);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_m%0d", name, i), int'(mot_set[i]), exp);
   endtask

   // Plant integrates mot_set>>>3 once per cycle and feeds the result back as rpm_sense.
   task automatic run_plant(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            plant[i]     = plant[i] + (int'(mot_set[i]) >>> 3);
            rpm_sense[i] = 16'(plant[i]);
         end
      end
   endtask

   task automatic check_plant(input string name, input int e0, input int e1,
                              input int e2, input int e3);
      check_near({name, "_left"},  plant[0], e0, 6);
      check_near({name, "_right"}, plant[1], e1, 6);
      check_near({name, "_front"}, plant[2], e2, 6);
      check_near({name, "_rear"},  plant[3], e3, 6);
   endtask

   initial begin
      vecs[0] = '{0,  0,  0,  2750, 2750, 2750, 2750,      0,     0,     0,     0};
      vecs[1] = '{0,  0,  0,  -100, -100, -100, -100,   5500,  5500,  5500,  5500};
      vecs[2] = '{0,  0,  0,  7000, 7000, 7000, 7000,  -5500, -5500, -5500, -5500};
      vecs[3] = '{3,  0,  3,     0,    0,    0,    0,   7900,  7900,  6700,  9100};
      vecs[4] = '{-4, 1,  0,  1000, 1000, 1000, 1000,    700,  -100,   300,   300};
      vecs[5] = '{3,  3, -4,  4000, 3000, 5000,    0,   1100,   700,  -500,  6300};
      vecs[6] = '{0,  0,  0,  5500, 5501,    0,   -1,  -5500, -5500,  5500,  5500};
      vecs[7] = '{-1, -2, 2, 32767, -32768, 1150, 2000, -7100,  5500,  1600,  1500};

      resetn = 1'b1;
      set_cmd(0, 0, 0);
      for (int i = 0; i < 4; i++) rpm_sense[i] = '0;

      // Reset holds everything at zero
      tick(); check_mot_all("rst1", 0);
      tick(); check_mot_all("rst2", 0);

      // First edge out of reset loads targets, mot_set follows one edge later
      resetn = 1'b0;
      tick(); check_mot_all("rel1", 0);
      tick(); check_mot_all("rel2", 5500);

      // Streamed vectors: command at cycle c, its sensor at c+2, result after edge c+2
      for (int cyc = 0; cyc < NV + 3; cyc++) begin
         if (cyc >= 3) begin
            for (int i = 0; i < 4; i++) begin
               if (exp_q.size() == 0) begin
                  check($sformatf("sb_empty_v%0d_m%0d", cyc - 3, i), 1, 0);
               end else begin
                  check($sformatf("vec%0d_m%0d", cyc - 3, i), int'(mot_set[i]),
                        exp_q.pop_front());
               end
            end
         end
         if (cyc < NV) begin
            set_cmd(vecs[cyc].alt, vecs[cyc].d0, vecs[cyc].d1);
            exp_q.push_back(vecs[cyc].m0);
            exp_q.push_back(vecs[cyc].m1);
            exp_q.push_back(vecs[cyc].m2);
            exp_q.push_back(vecs[cyc].m3);
         end
         if (cyc >= 2 && cyc < NV + 2) begin
            rpm_sense[0] = 16'(vecs[cyc-2].s0);
            rpm_sense[1] = 16'(vecs[cyc-2].s1);
            rpm_sense[2] = 16'(vecs[cyc-2].s2);
            rpm_sense[3] = 16'(vecs[cyc-2].s3);
         end
         tick();
      end
      check("sb_drained", exp_q.size(), 0);

      // Closed loop from a fresh reset with the plant at rest
      resetn = 1'b1;
      set_cmd(0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         plant[i]     = 0;
         rpm_sense[i] = '0;
      end
      tick(); check_mot_all("cl_rst1", 0);
      tick(); check_mot_all("cl_rst2", 0);
      resetn = 1'b0;
      run_plant(50); check_plant("hover", 2750, 2750, 2750, 2750);

      set_cmd(3, 0, 0);  run_plant(50); check_plant("alt_up",  3950, 3950, 3950, 3950);
      set_cmd(-4, 0, 0); run_plant(50); check_plant("alt_dn",  1150, 1150, 1150, 1150);
      set_cmd(0, 1, 0);  run_plant(50); check_plant("lat",     2950, 2550, 2750, 2750);
      set_cmd(3, 0, 3);  run_plant(50); check_plant("alt_lon", 3950, 3950, 3350, 4550);

      // Reset mid-transient clears outputs on the very next edge
      set_cmd(-4, 0, 0);
      run_plant(5);
      resetn = 1'b1;
      tick(); check_mot_all("mid_rst1", 0);
      tick(); check_mot_all("mid_rst2", 0);
      resetn = 1'b0;
      set_cmd(0, 0, 0);
      run_plant(50); check_plant("rehover", 2750, 2750, 2750, 2750);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
